// File: rtl/iteration_sequencer.sv
// Frame sequencer for the escape-time pixel function: initialises the pixel-state
// RAM, then runs MAX_PASS sweeps of read / evaluate / writeback / stream-out per pixel.
module iteration_sequencer #(
  parameter int X_PIX     = 256,
  parameter int Y_PIX     = 128,
  parameter int MAX_PASS  = 255,
  parameter int ITER_STEP = 256
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Start,
  input  logic        i_Abort,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [14:0] o_Ram_Addr,
  output logic        o_Ram_Re,
  input  logic [15:0] i_Ram_RdData,
  output logic        o_Ram_We,
  output logic [15:0] o_Ram_WrData,
  output logic [15:0] o_Complex,
  output logic [15:0] o_Iteration,
  input  logic [15:0] i_Writeback,
  input  logic [23:0] i_PXData,
  output logic [23:0] o_Pix_Data,
  output logic        o_Pix_Valid,
  input  logic        i_Pix_Ready,
  output logic        o_Pix_Last,
  output logic [2:0]  o_State
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] INIT = 3'd1;
  localparam logic [2:0] READ = 3'd2;
  localparam logic [2:0] CAPT = 3'd3;
  localparam logic [2:0] EXEC = 3'd4;
  localparam logic [2:0] PUSH = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  localparam logic [7:0]  X_LAST    = 8'(X_PIX - 1);
  localparam logic [6:0]  Y_LAST    = 7'(Y_PIX - 1);
  localparam logic [15:0] PASS_LAST = 16'(MAX_PASS);
  localparam logic [15:0] ITER_INC  = 16'(ITER_STEP);

  logic [2:0]  state_q;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [15:0] pass_q;
  logic [15:0] iter_q;
  logic [15:0] complex_q;
  logic [23:0] pix_data_q;
  logic        pix_valid_q;
  logic        pix_last_q;

  logic last_pix;
  logic handshake;

  // Pixel stream: a beat transfers on any rising edge where o_Pix_Valid and
  // i_Pix_Ready are both high; once valid is raised, data and last hold until then.
  assign last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
  assign handshake = pix_valid_q && i_Pix_Ready;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      pass_q      <= '0;
      iter_q      <= '0;
      complex_q   <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
    end else if (i_Abort) begin
      // Abort wins over everything; an un-accepted pixel is simply dropped.
      state_q     <= IDLE;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (i_Start) begin
            state_q <= INIT;
            x_q     <= '0;
            y_q     <= '0;
            pass_q  <= '0;
            iter_q  <= '0;
          end
        end
        INIT: begin
          if (last_pix) begin
            x_q     <= '0;
            y_q     <= '0;
            pass_q  <= 16'd1;
            iter_q  <= ITER_INC;
            state_q <= READ;
          end else if (y_q == Y_LAST) begin
            y_q <= '0;
            x_q <= x_q + 8'd1;
          end else begin
            y_q <= y_q + 7'd1;
          end
        end
        READ: state_q <= CAPT;
        CAPT: begin
          complex_q <= i_Ram_RdData;
          state_q   <= EXEC;
        end
        EXEC: begin
          pix_data_q  <= i_PXData;
          pix_valid_q <= 1'b1;
          pix_last_q  <= last_pix;
          state_q     <= PUSH;
        end
        PUSH: begin
          if (handshake) begin
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            if (!last_pix) begin
              if (y_q == Y_LAST) begin
                y_q <= '0;
                x_q <= x_q + 8'd1;
              end else begin
                y_q <= y_q + 7'd1;
              end
              state_q <= READ;
            end else if (pass_q < PASS_LAST) begin
              pass_q  <= pass_q + 16'd1;
              iter_q  <= iter_q + ITER_INC;
              x_q     <= '0;
              y_q     <= '0;
              state_q <= READ;
            end else begin
              state_q <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM strobes decode from the state register only, so no input reaches them.
  assign o_Ram_Addr   = {x_q, y_q};
  assign o_Ram_Re     = (state_q == READ);
  assign o_Ram_We     = (state_q == INIT) || (state_q == EXEC);
  assign o_Ram_WrData = (state_q == EXEC) ? i_Writeback :
                        (state_q == INIT) ? {1'b0, x_q, y_q} : 16'd0;

  assign o_Busy      = (state_q != IDLE) && (state_q != DONE);
  assign o_Done      = (state_q == DONE);
  assign o_Complex   = complex_q;
  assign o_Iteration = iter_q;
  assign o_Pix_Data  = pix_data_q;
  assign o_Pix_Valid = pix_valid_q;
  assign o_Pix_Last  = pix_last_q;
  assign o_State     = state_q;

endmodule

// File: tb/tb_iteration_sequencer.sv
// Bench for iteration_sequencer on a 2x2 frame with two passes, a RAM model and a
// stub pixel function; expected writes and pixels are queued and popped by monitors.
module tb_iteration_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_READ = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd4;
  localparam logic [2:0] S_PUSH = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic        i_Clk;
  logic        i_Rst_n;
  logic        i_Start;
  logic        i_Abort;
  logic        o_Busy;
  logic        o_Done;
  logic [14:0] o_Ram_Addr;
  logic        o_Ram_Re;
  logic [15:0] i_Ram_RdData;
  logic        o_Ram_We;
  logic [15:0] o_Ram_WrData;
  logic [15:0] o_Complex;
  logic [15:0] o_Iteration;
  logic [15:0] i_Writeback;
  logic [23:0] i_PXData;
  logic [23:0] o_Pix_Data;
  logic        o_Pix_Valid;
  logic        i_Pix_Ready;
  logic        o_Pix_Last;
  logic [2:0]  o_State;

  iteration_sequencer #(.X_PIX(2), .Y_PIX(2), .MAX_PASS(2), .ITER_STEP(256)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Start(i_Start), .i_Abort(i_Abort),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Ram_Addr(o_Ram_Addr), .o_Ram_Re(o_Ram_Re),
    .i_Ram_RdData(i_Ram_RdData), .o_Ram_We(o_Ram_We), .o_Ram_WrData(o_Ram_WrData),
    .o_Complex(o_Complex), .o_Iteration(o_Iteration), .i_Writeback(i_Writeback),
    .i_PXData(i_PXData), .o_Pix_Data(o_Pix_Data), .o_Pix_Valid(o_Pix_Valid),
    .i_Pix_Ready(i_Pix_Ready), .o_Pix_Last(o_Pix_Last), .o_State(o_State)
  );

  // clock / reset
  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc <= cyc + 1;

  // RAM model and stub pixel function
  logic [15:0] mem [0:32767];
  always @(posedge i_Clk) begin
    if (o_Ram_We) mem[o_Ram_Addr] <= o_Ram_WrData;
    if (o_Ram_Re) i_Ram_RdData <= mem[o_Ram_Addr];
  end
  assign i_Writeback = o_Complex + 16'd1;
  assign i_PXData    = {8'h00, o_Complex[7:0], o_Iteration[15:8]};

  // scoreboard
  logic [40:0] exp_q[$];
  logic [30:0] exp_wr_q[$];
  int          hs_cyc[$];
  int tests  = 0;
  int failed = 0;

  logic [14:0] addr_tab [4];
  initial begin
    addr_tab[0] = 15'd0;
    addr_tab[1] = 15'd1;
    addr_tab[2] = 15'd128;
    addr_tab[3] = 15'd129;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_init_writes();
    for (int i = 0; i < 4; i++) exp_wr_q.push_back({addr_tab[i], 1'b0, addr_tab[i]});
  endtask

  task automatic push_passes();
    logic [15:0] word;
    logic [15:0] iter;
    logic        last;
    for (int p = 1; p <= 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        word = {1'b0, addr_tab[i]} + 16'(p - 1);
        iter = 16'(p * 256);
        last = (i == 3);
        exp_q.push_back({last, iter, 8'h00, word[7:0], iter[15:8]});
        exp_wr_q.push_back({addr_tab[i], word + 16'd1});
      end
    end
  endtask

  // monitor: samples just before each rising edge, after the driver has settled inputs
  always begin
    logic [40:0] e;
    logic [30:0] w;
    @(negedge i_Clk);
    #3;
    if (o_Pix_Valid && i_Pix_Ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_pixel", {o_Pix_Last, o_Iteration, o_Pix_Data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("pixel", {o_Pix_Last, o_Iteration, o_Pix_Data}, e);
      end
    end
    if (o_Ram_We) begin
      if (exp_wr_q.size() == 0) check("unexpected_write", {o_Ram_Addr, o_Ram_WrData}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        w = exp_wr_q.pop_front();
        check("ram_write", {o_Ram_Addr, o_Ram_WrData}, w);
      end
    end
  end

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic pulse_start();
    i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cyc, input string name);
    bit hit = 0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge i_Clk);
      if (o_State == s) hit = 1;
    end
    if (!hit) check({"timeout_", name}, 64'(o_State), 64'(s));
  endtask

  task automatic check_queues_empty(input string name);
    check({name, "_pix_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_wr_left"}, 64'(exp_wr_q.size()), 64'd0);
  endtask

  initial begin
    bit hit;
    i_Rst_n = 1'b0; i_Start = 1'b0; i_Abort = 1'b0; i_Pix_Ready = 1'b1;
    repeat (3) @(negedge i_Clk);
    check("rst_state", 64'(o_State), 64'(S_IDLE));
    check("rst_ctrl", {o_Busy, o_Done, o_Ram_We, o_Ram_Re, o_Pix_Valid, o_Pix_Last}, 64'd0);
    check("rst_addr", 64'(o_Ram_Addr), 64'd0);
    check("rst_data", {o_Iteration, o_Complex, o_Pix_Data}, 64'd0);
    i_Rst_n = 1'b1;
    @(negedge i_Clk);

    // frame 1: free-running stream, stray start during READ of pass 1
    push_init_writes();
    push_passes();
    hs_cyc.delete();
    pulse_start();
    wait_state(S_READ, 20, "f1_read");
    pulse_start();
    wait_state(S_DONE, 200, "f1_done");
    check("f1_done", {o_Done, o_Busy}, 64'b10);
    check("f1_iter", 64'(o_Iteration), 64'h0200);
    check("f1_hs_count", 64'(hs_cyc.size()), 64'd8);
    for (int k = 1; k < hs_cyc.size(); k++) check("f1_pix_gap", 64'(hs_cyc[k] - hs_cyc[k-1]), 64'd4);
    for (int i = 0; i < 4; i++) check("f1_ram_final", 64'(mem[addr_tab[i]]), 64'({1'b0, addr_tab[i]} + 16'd2));
    check_queues_empty("f1");
    @(negedge i_Clk);

    // frame 2: back-pressure on pixel 2 (addr 1, pass 1)
    push_init_writes();
    push_passes();
    hs_cyc.delete();
    pulse_start();
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge i_Clk);
      if (o_State == S_EXEC && hs_cyc.size() == 1) hit = 1;
    end
    if (!hit) check("timeout_f2_exec", 64'(o_State), 64'(S_EXEC));
    i_Pix_Ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_Clk);
      check("stall_pix", {o_Pix_Valid, o_Pix_Last, o_Pix_Data}, {2'b10, 24'h000101});
      check("stall_ram", {o_Ram_We, o_Ram_Re, o_Ram_Addr}, {2'b00, 15'd1});
    end
    i_Pix_Ready = 1'b1;
    wait_state(S_DONE, 200, "f2_done");
    check("f2_hs_count", 64'(hs_cyc.size()), 64'd8);
    check_queues_empty("f2");

    // frame 3: abort while the first pixel waits in PUSH
    i_Pix_Ready = 1'b0;
    push_init_writes();
    exp_wr_q.push_back({15'd0, 16'd1});
    pulse_start();
    wait_state(S_PUSH, 50, "f3_push");
    i_Abort = 1'b1;
    @(negedge i_Clk);
    i_Abort = 1'b0;
    check("abort_state", 64'(o_State), 64'(S_IDLE));
    check("abort_ctrl", {o_Pix_Valid, o_Busy, o_Ram_We, o_Ram_Re}, 64'd0);
    check_queues_empty("f3");
    i_Pix_Ready = 1'b1;
    @(negedge i_Clk);

    // frame 4: restart after abort
    push_init_writes();
    push_passes();
    pulse_start();
    check("restart_init", {o_State, o_Ram_We, o_Ram_Addr, o_Ram_WrData}, {S_INIT, 1'b1, 15'd0, 16'd0});
    wait_state(S_DONE, 200, "f4_done");
    check_queues_empty("f4");

    // frame 5: asynchronous reset between edges during EXEC
    push_init_writes();
    pulse_start();
    wait_state(S_EXEC, 50, "f5_exec");
    #2;
    i_Rst_n = 1'b0;
    #1;
    check("arst_state", 64'(o_State), 64'(S_IDLE));
    check("arst_ctrl", {o_Busy, o_Done, o_Ram_We, o_Ram_Re, o_Pix_Valid, o_Pix_Last}, 64'd0);
    check("arst_data", {o_Ram_Addr, o_Iteration, o_Complex}, 64'd0);
    repeat (3) @(negedge i_Clk);
    check("arst_no_write", 64'(mem[0]), 64'd0);
    i_Rst_n = 1'b1;
    repeat (2) @(negedge i_Clk);
    check_queues_empty("f5");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
